// File: rtl/bkg_map_loader_if.sv
// rtl/bkg_map_loader_if.sv - tile ROM read port and map RAM write port bundle for bkg_map_loader
interface bkg_map_loader_if #(
  parameter int AW = 9,
  parameter int DW = 3
) ();
  logic          start;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_q;
  logic          wr_en;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_row;
  logic [4:0]    wr_col;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  // loader side
  modport master (
    input  start, rom_q, wr_ready,
    output rom_addr, wr_en, wr_addr, wr_row, wr_col, wr_data, busy, done
  );

  // ROM / map RAM / sequencer side
  modport slave (
    output start, rom_q, wr_ready,
    input  rom_addr, wr_en, wr_addr, wr_row, wr_col, wr_data, busy, done
  );
endinterface

// File: rtl/bkg_map_loader.sv
// rtl/bkg_map_loader.sv - copies the background tile ROM into the play-field map RAM (optional BKG_MAP_LOADER_COUNT_EN tile counter)
module bkg_map_loader #(
  parameter int DEPTH     = 300,
  parameter int COLS      = 20,
  parameter int AW        = 9,
  parameter int DW        = 3,
  parameter int COUNT_VAL = 5
) (
  input  logic             clk,
  input  logic             rst,
  bkg_map_loader_if.master bus
`ifdef BKG_MAP_LOADER_COUNT_EN
  , output logic [AW-1:0]  tile_count
`endif
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [4:0]    LAST_COL  = 5'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          armed;     // start accepted, counters cleared, FETCH begins next edge
  logic [AW-1:0] cnt;
  logic [3:0]    row;
  logic [4:0]    col;
  logic          free;
  logic          capture;
  logic          last;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // next-state logic: output stage is free when empty or being accepted this edge
  always_comb begin
    state_nxt = state;
    free      = ~bus.wr_en | bus.wr_ready;
    last      = (cnt == LAST_ADDR);
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (armed) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        capture = free;
        if (free && last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.wr_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.rom_addr = (state == S_FETCH) ? cnt : '0;
  assign bus.busy     = (state != S_IDLE);

  // fetch counters and the registered write stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed       <= 1'b0;
      cnt         <= '0;
      row         <= '0;
      col         <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_row  <= '0;
      bus.wr_col  <= '0;
      bus.wr_data <= '0;
      bus.done    <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      armed    <= 1'b0;
      case (state)
        S_IDLE: begin
          // a start landing in the arming cycle is dropped, the load is already on its way
          if (bus.start && !armed) begin
            armed <= 1'b1;
            cnt   <= '0;
            row   <= '0;
            col   <= '0;
          end
        end
        S_FETCH: begin
          if (capture) begin
            bus.wr_en   <= 1'b1;
            bus.wr_addr <= cnt;
            bus.wr_row  <= row;
            bus.wr_col  <= col;
            bus.wr_data <= bus.rom_q;
            // counter parks on the last address; DRAIN takes over from here
            if (!last) begin
              cnt <= cnt + 1'b1;
              if (col == LAST_COL) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        S_DRAIN: begin
          if (bus.wr_ready) begin
            bus.wr_en <= 1'b0;
            bus.done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BKG_MAP_LOADER_COUNT_EN
  localparam logic [DW-1:0] CVAL = DW'(COUNT_VAL);

  // count captured tiles matching CVAL; value is kept after done for the level-clear check
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_count <= '0;
    end else if (state == S_IDLE && bus.start && !armed) begin
      tile_count <= '0;
    end else if (capture && bus.rom_q == CVAL) begin
      tile_count <= tile_count + 1'b1;
    end
  end
`endif

endmodule
